// File: rtl/top_k_pkg.sv
// Shared types and helpers for the streaming top-K chain.
// TOP_K_SIGNED_EN selects two's-complement comparisons; the default compares unsigned.
package top_k_pkg;

  // Tokens carry data widened to this size so the cell type stays independent of DATA_WIDTH.
  localparam int unsigned MaxDataWidth = 64;

`ifdef TOP_K_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
    logic                    valid;
    logic                    last;
  } token_t;

  typedef enum logic [1:0] {
    StAccum = 2'd0,
    StFlush = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned k);
    return $clog2(k + 1);
  endfunction

  // Operands arrive already sign- or zero-extended to MaxDataWidth.
  function automatic logic greater(input logic [MaxDataWidth-1:0] a,
                                   input logic [MaxDataWidth-1:0] b);
`ifdef TOP_K_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

endpackage

// File: rtl/top_k_cell.sv
// One compare/keep stage: keeps the larger of stored and incoming value, forwards the other.
module top_k_cell
  import top_k_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  token_t                  tok_i,
  output token_t                  tok_o,
  output logic                    occ_o,
  output logic [MaxDataWidth-1:0] val_o
);

  logic                    occ_q, occ_d;
  logic [MaxDataWidth-1:0] val_q, val_d;
  token_t                  fwd_q, fwd_d;

  always_comb begin
    occ_d = occ_q;
    val_d = val_q;
    // The last marker always travels on, even when its value is absorbed here.
    fwd_d = '{data: tok_i.data, valid: 1'b0, last: tok_i.last};
    if (tok_i.valid) begin
      if (!occ_q) begin
        occ_d = 1'b1;
        val_d = tok_i.data;
      end else if (greater(tok_i.data, val_q)) begin
        val_d       = tok_i.data;
        fwd_d.data  = val_q;
        fwd_d.valid = 1'b1;
      end else begin
        fwd_d.valid = 1'b1;
      end
    end
    if (clear_i) begin
      occ_d = 1'b0;
      val_d = '0;
      fwd_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= 1'b0;
      val_q <= '0;
      fwd_q <= '0;
    end else begin
      occ_q <= occ_d;
      val_q <= val_d;
      fwd_q <= fwd_d;
    end
  end

  assign tok_o = fwd_q;
  assign occ_o = occ_q;
  assign val_o = val_q;

endmodule

// File: rtl/top_k_chain.sv
// Streaming top-K selector: K-deep systolic chain, then drains the K largest values descending.
// Define TOP_K_SIGNED_EN for signed comparisons (unsigned by default).
module top_k_chain
  import top_k_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  K          = 8,
  localparam int unsigned CNT_W      = cnt_w(K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data_TDATA,
  input  logic                  rx_data_TVALID,
  input  logic                  rx_data_TLAST,
  output logic                  rx_data_TREADY,
  output logic [DATA_WIDTH-1:0] tx_data_TDATA,
  output logic                  tx_data_TVALID,
  output logic                  tx_data_TLAST,
  input  logic                  tx_data_TREADY,
  output logic [DATA_WIDTH-1:0] max_TDATA,
  output logic                  max_TVALID,
  output logic [CNT_W-1:0]      count
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  token_t                  tok [K+1];
  logic [K-1:0]            occ;
  logic [MaxDataWidth-1:0] val [K];
  logic [MaxDataWidth-1:0] in_data;
  logic                    rx_hs, tx_hs, clear;

  assign rx_data_TREADY = (state_q == StAccum);
  assign rx_hs          = rx_data_TVALID & rx_data_TREADY;
  assign tx_data_TVALID = (state_q == StDrain);
  assign tx_hs          = tx_data_TVALID & tx_data_TREADY;
  assign tx_data_TLAST  = tx_data_TVALID & (idx_q == count - CNT_W'(1));
  assign clear          = tx_hs & tx_data_TLAST;

  // Widen once at the chain entry so every cell compares at full token width.
  always_comb begin
    in_data                   = '0;
    in_data[DATA_WIDTH-1:0]   = rx_data_TDATA;
    for (int unsigned i = DATA_WIDTH; i < MaxDataWidth; i++) begin
      in_data[i] = SignedEn & rx_data_TDATA[DATA_WIDTH-1];
    end
  end

  assign tok[0] = '{data: in_data, valid: rx_hs, last: rx_hs & rx_data_TLAST};

  for (genvar g = 0; g < K; g++) begin : g_cell
    top_k_cell u_cell (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .tok_i   (tok[g]),
      .tok_o   (tok[g+1]),
      .occ_o   (occ[g]),
      .val_o   (val[g])
    );
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < K; i++) begin
      count = count + CNT_W'(occ[i]);
    end
  end

  always_comb begin
    tx_data_TDATA = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (idx_q == CNT_W'(i)) tx_data_TDATA = val[i][DATA_WIDTH-1:0];
    end
  end

  assign max_TDATA  = val[0][DATA_WIDTH-1:0];
  assign max_TVALID = occ[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StAccum: if (rx_hs && rx_data_TLAST) state_d = StFlush;
      // Bits leaving the last cell: the set is fully sorted once the last marker emerges.
      StFlush: if (tok[K].last) begin
        state_d = StDrain;
        idx_d   = '0;
      end
      StDrain: if (tx_hs) begin
        if (tx_data_TLAST) begin
          state_d = StAccum;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_top_k_chain.sv
// Directed self-checking bench for top_k_chain with K=4, DATA_WIDTH=32.
module tb_top_k_chain;

  localparam int unsigned DW = 32;
  localparam int unsigned KK = 4;
  localparam int unsigned CW = $clog2(KK + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data_TDATA = '0;
  logic          rx_data_TVALID = 1'b0;
  logic          rx_data_TLAST = 1'b0;
  logic          rx_data_TREADY;
  logic [DW-1:0] tx_data_TDATA;
  logic          tx_data_TVALID;
  logic          tx_data_TLAST;
  logic          tx_data_TREADY = 1'b1;
  logic [DW-1:0] max_TDATA;
  logic          max_TVALID;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  top_k_chain #(
    .DATA_WIDTH (DW),
    .K          (KK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_TDATA  (rx_data_TDATA),
    .rx_data_TVALID (rx_data_TVALID),
    .rx_data_TLAST  (rx_data_TLAST),
    .rx_data_TREADY (rx_data_TREADY),
    .tx_data_TDATA  (tx_data_TDATA),
    .tx_data_TVALID (tx_data_TVALID),
    .tx_data_TLAST  (tx_data_TLAST),
    .tx_data_TREADY (tx_data_TREADY),
    .max_TDATA      (max_TDATA),
    .max_TVALID     (max_TVALID),
    .count          (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    check_eq("rx_ready_before_send", 64'(rx_data_TREADY), 64'd1);
    rx_data_TDATA  = d;
    rx_data_TVALID = 1'b1;
    rx_data_TLAST  = l;
    tick();
    rx_data_TVALID = 1'b0;
    rx_data_TLAST  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [DW-1:0] d, input logic l);
    int n = 0;
    tx_data_TREADY = 1'b1;
    while (!tx_data_TVALID && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 64'(tx_data_TVALID), 64'd1);
    check_eq({tag, "_data"}, 64'(tx_data_TDATA), 64'(d));
    check_eq({tag, "_last"}, 64'(tx_data_TLAST), 64'(l));
    tick();
  endtask

  task automatic send_set1();
    send(32'd5, 1'b0);
    send(32'd1, 1'b0);
    send(32'd9, 1'b0);
    send(32'd3, 1'b0);
    send(32'd7, 1'b1);
  endtask

  logic [DW-1:0] exp4 [4];

  initial begin
    exp4[0] = 32'd9; exp4[1] = 32'd7; exp4[2] = 32'd5; exp4[3] = 32'd3;

    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_rx_ready", 64'(rx_data_TREADY), 64'd1);
    check_eq("rst_tx_valid", 64'(tx_data_TVALID), 64'd0);
    check_eq("rst_tx_last", 64'(tx_data_TLAST), 64'd0);
    check_eq("rst_max_valid", 64'(max_TVALID), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_tx_data", 64'(tx_data_TDATA), 64'd0);
    check_eq("rst_max_data", 64'(max_TDATA), 64'd0);

    // Scenario 1: ordering, latency and ready timing.
    send_set1();
    check_eq("s1_rx_ready_low", 64'(rx_data_TREADY), 64'd0);
    check_eq("s1_valid_c1", 64'(tx_data_TVALID), 64'd0);
    repeat (KK - 1) tick();
    check_eq("s1_valid_cK", 64'(tx_data_TVALID), 64'd0);
    tick();
    check_eq("s1_valid_cK1", 64'(tx_data_TVALID), 64'd1);
    check_eq("s1_count", 64'(count), 64'd4);
    check_eq("s1_max", 64'(max_TDATA), 64'd9);
    recv("s1_b0", 32'd9, 1'b0);
    check_eq("s1_rx_ready_drain", 64'(rx_data_TREADY), 64'd0);
    recv("s1_b1", 32'd7, 1'b0);
    recv("s1_b2", 32'd5, 1'b0);
    recv("s1_b3", 32'd3, 1'b1);
    check_eq("s1_rx_ready_after", 64'(rx_data_TREADY), 64'd1);
    check_eq("s1_count_cleared", 64'(count), 64'd0);

    // Scenario 2: short set, then single-element set.
    send(32'd2, 1'b0);
    send(32'd4, 1'b1);
    recv("s2_b0", 32'd4, 1'b0);
    check_eq("s2_count_drain", 64'(count), 64'd2);
    recv("s2_b1", 32'd2, 1'b1);
    send(32'd1, 1'b1);
    recv("s2_single", 32'd1, 1'b1);

    // Scenario 3: ties and overflow.
    send(32'd6, 1'b0);
    check_eq("s3_max_data", 64'(max_TDATA), 64'd6);
    check_eq("s3_max_valid", 64'(max_TVALID), 64'd1);
    for (int i = 0; i < 4; i++) send(32'd6, (i == 3));
    for (int i = 0; i < 4; i++) recv("s3_b", 32'd6, (i == 3));

    // Scenario 4: backpressure 1010... during drain.
    send_set1();
    begin
      int j = 0;
      int n = 0;
      while (!tx_data_TVALID && n < 20) begin
        tick();
        n++;
      end
      n = 0;
      while (j < 4 && n < 20) begin
        tx_data_TREADY = ((n % 2) == 0);
        check_eq("s4_valid", 64'(tx_data_TVALID), 64'd1);
        check_eq("s4_data", 64'(tx_data_TDATA), 64'(exp4[j]));
        check_eq("s4_last", 64'(tx_data_TLAST), 64'(j == 3));
        tick();
        if (tx_data_TREADY) j++;
        n++;
      end
      check_eq("s4_beats", 64'(j), 64'd4);
      tx_data_TREADY = 1'b1;
      check_eq("s4_rx_ready_after", 64'(rx_data_TREADY), 64'd1);
    end

    // Scenario 5: reset mid-drain discards the set.
    send_set1();
    recv("s5_b0", 32'd9, 1'b0);
    recv("s5_b1", 32'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s5_tx_valid", 64'(tx_data_TVALID), 64'd0);
    check_eq("s5_count", 64'(count), 64'd0);
    check_eq("s5_rx_ready", 64'(rx_data_TREADY), 64'd1);
    send(32'd8, 1'b1);
    recv("s5_single", 32'd8, 1'b1);
    check_eq("s5_idle_after", 64'(tx_data_TVALID), 64'd0);

    // Scenario 6: signedness of the comparison.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd2, 1'b1);
`ifdef TOP_K_SIGNED_EN
    recv("s6_b0", 32'd2, 1'b0);
    recv("s6_b1", 32'hFFFF_FFFF, 1'b1);
`else
    recv("s6_b0", 32'hFFFF_FFFF, 1'b0);
    recv("s6_b1", 32'd2, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
